// File: rtl/butterfly_stream_if.sv
// Operand/result stream bundle for butterfly_stream: valid/ready handshakes on both sides,
// plus the sticky overflow flag and its clear.
interface butterfly_stream_if #(
    parameter int DATA_W = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     inverse;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic signed [DATA_W-1:0] w_re;
    logic signed [DATA_W-1:0] w_im;
    logic                     out_valid;
    logic                     out_ready;
    logic        [DATA_W-1:0] y_re;
    logic        [DATA_W-1:0] y_im;
    logic        [DATA_W-1:0] z_re;
    logic        [DATA_W-1:0] z_im;
    logic                     ovf;
    logic                     ovf_clr;

    modport slave (
        input  in_valid, inverse, a_re, a_im, b_re, b_im, w_re, w_im,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, y_re, y_im, z_re, z_im, ovf
    );

    modport master (
        output in_valid, inverse, a_re, a_im, b_re, b_im, w_re, w_im,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, y_re, y_im, z_re, z_im, ovf
    );
endinterface

// File: rtl/butterfly_stream.sv
// Three-stage streaming radix-2 butterfly: y = a + w*b, z = a - w*b, optional conj(w) and halving.
// Define BUTTERFLY_STREAM_ROUND_EN for round-half-up in place of truncation.
module butterfly_stream #(
    parameter int DATA_W    = 8,
    parameter int SCALE_OUT = 0
) (
    input logic               clk,
    input logic               reset,
    butterfly_stream_if.slave bus
);
    localparam int PW = 2 * DATA_W;
    localparam int SW = PW + 2;
    localparam int RW = DATA_W + 3;
`ifdef BUTTERFLY_STREAM_ROUND_EN
    localparam int RND_P = 1 << (DATA_W - 2);
    localparam int RND_S = 1;
`else
    localparam int RND_P = 0;
    localparam int RND_S = 0;
`endif
    localparam logic signed [RW-1:0] MAX_V = RW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [RW-1:0] MIN_V = -RW'(1 << (DATA_W - 1));

    logic advance;
    logic v1_reg;
    logic v2_reg;
    logic out_valid_reg;
    logic ovf_reg;
    logic ovf_next;
    logic ovf_set;

    logic                     inv1_reg;
    logic signed [DATA_W-1:0] a_re1_reg;
    logic signed [DATA_W-1:0] a_im1_reg;
    logic signed [DATA_W-1:0] b_re1_reg;
    logic signed [DATA_W-1:0] b_im1_reg;
    logic signed [DATA_W-1:0] w_re1_reg;
    logic signed [DATA_W-1:0] w_im1_reg;

    logic                     inv2_reg;
    logic signed [DATA_W-1:0] a_re2_reg;
    logic signed [DATA_W-1:0] a_im2_reg;

    logic signed [DATA_W-1:0] mul_x     [4];
    logic signed [DATA_W-1:0] mul_y     [4];
    logic signed [PW-1:0]     prod_next [4];
    logic signed [PW-1:0]     prod_reg  [4];

    logic signed [SW-1:0]     p_re_sum;
    logic signed [SW-1:0]     p_im_sum;
    logic signed [RW-1:0]     p_re_q;
    logic signed [RW-1:0]     p_im_q;
    logic signed [RW-1:0]     a_re_x;
    logic signed [RW-1:0]     a_im_x;
    logic signed [RW-1:0]     pre       [4];
    logic signed [RW-1:0]     scaled    [4];
    logic [3:0]               clip;
    logic [DATA_W-1:0]        res_next  [4];
    logic [DATA_W-1:0]        res_reg   [4];

    // Every stage moves in lockstep; a full output register blocks the whole pipe.
    assign advance = !out_valid_reg || bus.out_ready;

    // Product order: re*re, im*im, re*im (w_re*b_im), im*re (w_im*b_re).
    assign mul_x[0] = w_re1_reg;
    assign mul_y[0] = b_re1_reg;
    assign mul_x[1] = w_im1_reg;
    assign mul_y[1] = b_im1_reg;
    assign mul_x[2] = w_re1_reg;
    assign mul_y[2] = b_im1_reg;
    assign mul_x[3] = w_im1_reg;
    assign mul_y[3] = b_re1_reg;

    // Full 2*DATA_W products so that (-1)*(-1) is representable.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mul
            assign prod_next[gi] = PW'(mul_x[gi]) * PW'(mul_y[gi]);
        end
    endgenerate

    assign p_re_sum = inv2_reg ? (SW'(prod_reg[0]) + SW'(prod_reg[1]))
                               : (SW'(prod_reg[0]) - SW'(prod_reg[1]));
    assign p_im_sum = inv2_reg ? (SW'(prod_reg[2]) - SW'(prod_reg[3]))
                               : (SW'(prod_reg[2]) + SW'(prod_reg[3]));

    // Back to Q1.(DATA_W-1) scale with two guard bits of integer headroom.
    assign p_re_q = RW'((p_re_sum + SW'(RND_P)) >>> (DATA_W - 1));
    assign p_im_q = RW'((p_im_sum + SW'(RND_P)) >>> (DATA_W - 1));

    assign a_re_x = RW'(a_re2_reg);
    assign a_im_x = RW'(a_im2_reg);

    assign pre[0] = a_re_x + p_re_q;
    assign pre[1] = a_im_x + p_im_q;
    assign pre[2] = a_re_x - p_re_q;
    assign pre[3] = a_im_x - p_im_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_out
            if (SCALE_OUT != 0) begin : g_scale
                assign scaled[gi] = (pre[gi] + RW'(RND_S)) >>> 1;
            end else begin : g_noscale
                assign scaled[gi] = pre[gi];
            end
            assign clip[gi]     = (scaled[gi] > MAX_V) || (scaled[gi] < MIN_V);
            assign res_next[gi] = (scaled[gi] > MAX_V) ? MAX_V[DATA_W-1:0] :
                                  (scaled[gi] < MIN_V) ? MIN_V[DATA_W-1:0] :
                                                         scaled[gi][DATA_W-1:0];
        end
    endgenerate

    // A clamp on a result being loaded wins over a simultaneous clear.
    assign ovf_set = advance && v2_reg && (|clip);

    always_comb begin
        ovf_next = ovf_reg;
        if (ovf_set) begin
            ovf_next = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_reg        <= 1'b0;
            v2_reg        <= 1'b0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_reg[i] <= '0;
            end
        end else begin
            ovf_reg <= ovf_next;
            if (advance) begin
                v1_reg        <= bus.in_valid;
                v2_reg        <= v1_reg;
                out_valid_reg <= v2_reg;
                if (v2_reg) begin
                    for (int i = 0; i < 4; i++) begin
                        res_reg[i] <= res_next[i];
                    end
                end
            end
        end
    end

    // Datapath registers need no reset: their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (advance) begin
            if (bus.in_valid) begin
                inv1_reg  <= bus.inverse;
                a_re1_reg <= bus.a_re;
                a_im1_reg <= bus.a_im;
                b_re1_reg <= bus.b_re;
                b_im1_reg <= bus.b_im;
                w_re1_reg <= bus.w_re;
                w_im1_reg <= bus.w_im;
            end
            if (v1_reg) begin
                inv2_reg  <= inv1_reg;
                a_re2_reg <= a_re1_reg;
                a_im2_reg <= a_im1_reg;
                for (int i = 0; i < 4; i++) begin
                    prod_reg[i] <= prod_next[i];
                end
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_reg;
    assign bus.y_re      = res_reg[0];
    assign bus.y_im      = res_reg[1];
    assign bus.z_re      = res_reg[2];
    assign bus.z_im      = res_reg[3];
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_butterfly_stream.sv
// Scoreboard bench for butterfly_stream: a reference model fills an expected-result queue
// as operand sets are accepted; results are popped and compared as they leave the DUT.
module tb_butterfly_stream;
    localparam int W         = 8;
    localparam int SCALE_OUT = 0;
`ifdef BUTTERFLY_STREAM_ROUND_EN
    localparam int RND_P = 1 << (W - 2);
    localparam int RND_S = 1;
`else
    localparam int RND_P = 0;
    localparam int RND_S = 0;
`endif

    typedef struct packed {
        logic [7:0] ar;
        logic [7:0] ai;
        logic [7:0] br;
        logic [7:0] bi;
        logic [7:0] wr;
        logic [7:0] wi;
        logic       inv;
    } stim_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    butterfly_stream_if #(.DATA_W(W)) bus ();
    butterfly_stream #(.DATA_W(W), .SCALE_OUT(SCALE_OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    stim_t       stim_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic stim_t mk(input logic [7:0] ar, ai, br, bi, wr, wi, input logic inv);
        stim_t s;
        s.ar = ar; s.ai = ai; s.br = br; s.bi = bi; s.wr = wr; s.wi = wi; s.inv = inv;
        return s;
    endfunction

    // Reference: integer arithmetic, floor shifts (or half-up), clamp to DATA_W.
    function automatic logic [31:0] model(input stim_t s);
        int ar, ai, br, bi, wr, wi, pre, pim;
        int v [4];
        logic [7:0] o [4];
        ar = int'($signed(s.ar)); ai = int'($signed(s.ai));
        br = int'($signed(s.br)); bi = int'($signed(s.bi));
        wr = int'($signed(s.wr)); wi = int'($signed(s.wi));
        if (s.inv) begin
            pre = wr * br + wi * bi;
            pim = wr * bi - wi * br;
        end else begin
            pre = wr * br - wi * bi;
            pim = wr * bi + wi * br;
        end
        pre = (pre + RND_P) >>> (W - 1);
        pim = (pim + RND_P) >>> (W - 1);
        v[0] = ar + pre; v[1] = ai + pim; v[2] = ar - pre; v[3] = ai - pim;
        for (int i = 0; i < 4; i++) begin
            if (SCALE_OUT != 0) v[i] = (v[i] + RND_S) >>> 1;
            if (v[i] > 127) v[i] = 127;
            else if (v[i] < -128) v[i] = -128;
            o[i] = 8'(v[i]);
        end
        return {o[0], o[1], o[2], o[3]};
    endfunction

    task automatic step(output bit in_fire, output bit out_fire, output logic [31:0] got);
        stim_t s;
        if (stim_q.size() > 0) begin
            s = stim_q[0];
            bus.a_re = s.ar; bus.a_im = s.ai; bus.b_re = s.br; bus.b_im = s.bi;
            bus.w_re = s.wr; bus.w_im = s.wi; bus.inverse = s.inv;
            bus.in_valid = 1'b1;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        in_fire  = bus.in_valid && bus.in_ready;
        out_fire = bus.out_valid && bus.out_ready;
        got      = {bus.y_re, bus.y_im, bus.z_re, bus.z_im};
        if (in_fire) begin
            s = stim_q.pop_front();
            exp_q.push_back(model(s));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.ovf_clr = 1'b0; bus.inverse = 1'b0;
        bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0; bus.w_re = '0; bus.w_im = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++;
        if ({bus.y_re, bus.y_im, bus.z_re, bus.z_im} !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 00000000", {bus.y_re, bus.y_im, bus.z_re, bus.z_im});
        end
        n_checks++;
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        $display("reset: out_valid=%b in_ready=%b ovf=%b", bus.out_valid, bus.in_ready, bus.ovf);
    endtask

    task automatic test_basic();
        bit fi, fo; logic [31:0] got, exp; int lat; bit seen;
        stim_q.push_back(mk(8'h20, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 1'b0));
        lat = 0; seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            step(fi, fo, got);
            lat++;
            if (bus.out_valid) seen = 1;
        end
        n_checks++;
        if (!seen || lat != 3) begin n_fail++; $display("FAIL basic_latency: got %0d cycles expected 3", lat); end
        step(fi, fo, got);
        n_checks++;
        if (!fo || exp_q.size() == 0) begin
            n_fail++; $display("FAIL basic_transfer: got out_fire=%b expected 1", fo);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp || got !== 32'h4000_0000) begin
                n_fail++; $display("FAIL basic_result: got %h expected %h", got, 32'h4000_0000);
            end
        end
        $display("basic: result=%h latency=%0d", got, lat);
    endtask

    task automatic test_inverse();
        bit fi, fo; logic [31:0] got, exp; int n; logic [31:0] req [2];
        req[0] = 32'h0020_00E0;
        req[1] = 32'h00E0_0020;
        stim_q.push_back(mk(8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40, 1'b0));
        stim_q.push_back(mk(8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h40, 1'b1));
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            step(fi, fo, got);
            if (fo) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp || got !== req[n]) begin
                    n_fail++; $display("FAIL inverse_%0d: got %h expected %h", n, got, req[n]);
                end
                $display("inverse=%0d: result=%h", n, got);
                n++;
            end
        end
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL inverse_count: got %0d expected 2", n); end
    endtask

    task automatic test_saturation();
        bit fi, fo; logic [31:0] got, exp; int n;
        stim_q.push_back(mk(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0));
        stim_q.push_back(mk(8'h20, 8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 1'b0));
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            step(fi, fo, got);
            if (fo) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp || (n == 0 && got !== 32'h7F00_0100)) begin
                    n_fail++; $display("FAIL sat_result_%0d: got %h expected %h", n, got, exp);
                end
                $display("saturation set %0d: result=%h ovf=%b", n, got, bus.ovf);
                n++;
            end
        end
        n_checks++;
        if (n != 2 || bus.ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf_sticky: got %b expected 1", bus.ovf); end
        bus.ovf_clr = 1'b1;
        step(fi, fo, got);
        bus.ovf_clr = 1'b0;
        n_checks++;
        if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL sat_ovf_clear: got %b expected 0", bus.ovf); end
        // Clear held across the cycle in which the clamped result is loaded.
        bus.ovf_clr = 1'b1;
        stim_q.push_back(mk(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0));
        for (int c = 0; c < 20 && !bus.out_valid; c++) step(fi, fo, got);
        bus.ovf_clr = 1'b0;
        n_checks++;
        if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins: got %b expected 1", bus.ovf); end
        step(fi, fo, got);
        n_checks++;
        if (!fo || exp_q.size() == 0) begin
            n_fail++; $display("FAIL sat_set_wins_transfer: got out_fire=%b expected 1", fo);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin n_fail++; $display("FAIL sat_set_wins_result: got %h expected %h", got, exp); end
        end
        $display("saturation with clear: ovf=%b", bus.ovf);
    endtask

    task automatic test_rounding();
        bit fi, fo; logic [31:0] got, exp, req; bit done;
`ifdef BUTTERFLY_STREAM_ROUND_EN
        req = 32'h0100_FF00;
`else
        req = 32'h0000_0000;
`endif
        stim_q.push_back(mk(8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h00, 1'b0));
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            step(fi, fo, got);
            if (fo) begin
                exp = exp_q.pop_front();
                done = 1;
                n_checks++;
                if (got !== exp || got !== req) begin n_fail++; $display("FAIL rounding: got %h expected %h", got, req); end
                $display("rounding: result=%h", got);
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rounding_timeout: got no result expected 1"); end
    endtask

    task automatic test_random();
        bit fi, fo; logic [31:0] got, exp; int n;
        stim_q.push_back(mk(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0));
        for (int i = 0; i < 20; i++) begin
            stim_q.push_back(mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                                8'($urandom), 8'($urandom), 1'($urandom)));
        end
        n = 0;
        for (int c = 0; c < 400 && n < 21; c++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step(fi, fo, got);
            if (fo) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp || (n == 0 && got !== 32'h807F_8080)) begin
                    n_fail++; $display("FAIL random_%0d: got %h expected %h", n, got, exp);
                end
                $display("random set %0d: result=%h", n, got);
                n++;
            end
        end
        bus.out_ready = 1'b1;
        n_checks++;
        if (n != 21) begin n_fail++; $display("FAIL random_count: got %0d expected 21", n); end
    endtask

    task automatic test_back_to_back();
        bit fi, fo; logic [31:0] got, exp, hold; int acc, n, extra;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stim_q.push_back(mk(8'(8'h10 + i), 8'(8'h20 - i), 8'h40, 8'(i * 3), 8'h30, 8'(8'hF0 + i), 1'(i)));
        end
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            step(fi, fo, got);
            if (fi) acc++;
        end
        n_checks++;
        if (acc != 3 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_fill: got accepted=%0d in_ready=%b expected 3 and 0", acc, bus.in_ready);
        end
        hold = {bus.y_re, bus.y_im, bus.z_re, bus.z_im};
        for (int c = 0; c < 3; c++) begin
            step(fi, fo, got);
            if (fi) acc++;
        end
        n_checks++;
        if ({bus.y_re, bus.y_im, bus.z_re, bus.z_im} !== hold || acc != 3 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got %h expected %h", {bus.y_re, bus.y_im, bus.z_re, bus.z_im}, hold);
        end
        bus.out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step(fi, fo, got);
            if (fo) begin
                exp = exp_q.pop_front();
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL bp_result_%0d: got %h expected %h", n, got, exp); end
                $display("backpressure set %0d: result=%h", n, got);
                n++;
            end
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            step(fi, fo, got);
            if (fo) extra++;
        end
        n_checks++;
        if (n != 5 || extra != 0) begin n_fail++; $display("FAIL bp_count: got %0d (+%0d extra) expected 5", n, extra); end
    endtask

    task automatic test_mid_reset();
        bit fi, fo; logic [31:0] got; int stale;
        stim_q.push_back(mk(8'h7F, 8'h00, 8'h7F, 8'h00, 8'h7F, 8'h00, 1'b0));
        for (int c = 0; c < 20 && exp_q.size() + stim_q.size() > 0; c++) begin
            step(fi, fo, got);
            if (fo) void'(exp_q.pop_front());
        end
        n_checks++;
        if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre_ovf: got %b expected 1", bus.ovf); end
        stim_q.push_back(mk(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 1'b0));
        stim_q.push_back(mk(8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b1));
        step(fi, fo, got);
        step(fi, fo, got);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        stim_q.delete();
        n_checks++;
        if (bus.out_valid !== 1'b0 || {bus.y_re, bus.y_im, bus.z_re, bus.z_im} !== 32'h0 || bus.ovf !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_state: got valid=%b out=%h ovf=%b expected 0 00000000 0",
                               bus.out_valid, {bus.y_re, bus.y_im, bus.z_re, bus.z_im}, bus.ovf);
        end
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            step(fi, fo, got);
            if (bus.out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL mid_reset_stale: got %0d valid cycles expected 0", stale); end
        $display("mid-stream reset: stale outputs=%0d", stale);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_saturation();
        test_rounding();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
